// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: program counter, memory fetch handshake, branch redirect and stall handling.
// Optional direct-mapped instruction cache, built only when the macro IF_ICACHE_EN is defined.
module if_stage #(
    parameter int ICACHE_LINES = 128
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [5:0]  stall_in,
    input  logic        branch_or_not,
    input  logic [31:0] branch_target,
    input  logic        mem_done,
    input  logic [31:0] mem_instru,
    output logic        if_req,
    output logic [31:0] if_addr,
    output logic        stall_req,
    output logic [31:0] output_pc,
    output logic [31:0] output_instru
);
    typedef enum logic [0:0] { IDLE = 1'b0, WAIT_MEM = 1'b1 } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic        req_s;
    logic [31:0] addr_s, out_pc_s, out_instru_s;
    logic        hold_valid_r, hold_valid_s;
    logic [31:0] hold_instru_r, hold_instru_s;
    logic        hit_s;
    logic [31:0] line_s;
    logic        done_s, fill_s;
    logic        unused_s;

    assign unused_s  = ^stall_in[5:1];
    assign stall_req = (state_r == WAIT_MEM);
    // A done pulse only counts while our own request is outstanding.
    assign done_s    = mem_done & if_req;
    assign fill_s    = rdy_in & ~rst_in & done_s & (state_r == WAIT_MEM);

`ifdef IF_ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [31:0]             data_r [ICACHE_LINES];
    logic [TAG_W-1:0]        tag_r  [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] valid_r;
    logic [IDX_W-1:0]        rd_idx_s, wr_idx_s;

    assign rd_idx_s = pc_r[IDX_W+1:2];
    assign wr_idx_s = if_addr[IDX_W+1:2];
    assign hit_s    = valid_r[rd_idx_s] && (tag_r[rd_idx_s] == pc_r[31:IDX_W+2]);
    assign line_s   = data_r[rd_idx_s];

    // Valid bits: cleared only by reset, set by every accepted fill.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_r <= '0;
        end else if (fill_s) begin
            valid_r[wr_idx_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Data and tag arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk_in) begin
        if (fill_s) begin
            data_r[wr_idx_s] <= mem_instru;
            tag_r[wr_idx_s]  <= if_addr[31:IDX_W+2];
        end
    end
`else
    logic [$clog2(ICACHE_LINES)-1:0] unused_idx_s;
    assign unused_idx_s = pc_r[$clog2(ICACHE_LINES)+1:2];
    assign hit_s        = 1'b0;
    assign line_s       = 32'd0;
`endif

    // Next-state logic: branch beats stall beats normal fetch.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        req_s         = if_req;
        addr_s        = if_addr;
        out_pc_s      = output_pc;
        out_instru_s  = output_instru;
        hold_valid_s  = hold_valid_r;
        hold_instru_s = hold_instru_r;
        if (branch_or_not) begin
            pc_s         = branch_target;
            state_s      = IDLE;
            req_s        = 1'b0;
            out_pc_s     = 32'd0;
            out_instru_s = 32'd0;
            hold_valid_s = 1'b0;
        end else if (stall_in[0]) begin
            // Park a word that returns while frozen so it is not refetched.
            if ((state_r == WAIT_MEM) && done_s) begin
                req_s         = 1'b0;
                hold_valid_s  = 1'b1;
                hold_instru_s = mem_instru;
            end else begin
                hold_valid_s = hold_valid_r;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (hit_s) begin
                        out_pc_s     = pc_r;
                        out_instru_s = line_s;
                        pc_s         = pc_r + 32'd4;
                    end else begin
                        req_s        = 1'b1;
                        addr_s       = pc_r;
                        state_s      = WAIT_MEM;
                        out_pc_s     = 32'd0;
                        out_instru_s = 32'd0;
                    end
                end
                WAIT_MEM: begin
                    if (hold_valid_r) begin
                        out_pc_s     = if_addr;
                        out_instru_s = hold_instru_r;
                        pc_s         = if_addr + 32'd4;
                        state_s      = IDLE;
                        hold_valid_s = 1'b0;
                    end else if (done_s) begin
                        req_s        = 1'b0;
                        out_pc_s     = if_addr;
                        out_instru_s = mem_instru;
                        pc_s         = if_addr + 32'd4;
                        state_s      = IDLE;
                    end else begin
                        req_s = if_req;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Stage registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r       <= IDLE;
            pc_r          <= 32'd0;
            if_req        <= 1'b0;
            if_addr       <= 32'd0;
            output_pc     <= 32'd0;
            output_instru <= 32'd0;
            hold_valid_r  <= 1'b0;
            hold_instru_r <= 32'd0;
        end else if (rdy_in) begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            if_req        <= req_s;
            if_addr       <= addr_s;
            output_pc     <= out_pc_s;
            output_instru <= out_instru_s;
            hold_valid_r  <= hold_valid_s;
            hold_instru_r <= hold_instru_s;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: expected pc/instruction pairs are queued when the memory word
// (or a cache hit) is provoked, and compared against issued outputs recorded by a monitor.
module tb_if_stage;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, branch_or_not, mem_done;
    logic [5:0]  stall_in;
    logic [31:0] branch_target, mem_instru;
    logic        if_req, stall_req;
    logic [31:0] if_addr, output_pc, output_instru;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    logic        fresh = 1'b0;

    if_stage dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall_in(stall_in),
        .branch_or_not(branch_or_not), .branch_target(branch_target),
        .mem_done(mem_done), .mem_instru(mem_instru),
        .if_req(if_req), .if_addr(if_addr), .stall_req(stall_req),
        .output_pc(output_pc), .output_instru(output_instru)
    );

    always #5 clk_in = ~clk_in;

    // An edge produces a new output only when enabled, not reset, not redirected and not stalled.
    always @(posedge clk_in) fresh <= rdy_in && !rst_in && !branch_or_not && !stall_in[0];
    always @(negedge clk_in) if (fresh && output_instru != 32'd0) obs_q.push_back({output_pc, output_instru});

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a << 3) + 32'h13;
    endfunction

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_req(input logic [31:0] a, input string name);
        int n = 0;
        while (if_req !== 1'b1 && n < 20) begin cyc(); n++; end
        checks++;
        if (if_req !== 1'b1 || if_addr !== a) begin
            failures++;
            $display("FAIL %s_req: if_req=%b if_addr=%h, expected 1 and %h", name, if_req, if_addr, a);
        end
    endtask

    task automatic serve(input logic [31:0] a, input int lat);
        wait_req(a, "serve");
        repeat (lat - 1) cyc();
        mem_done = 1'b1;
        mem_instru = word_of(a);
        exp_q.push_back({a, word_of(a)});
        cyc();
        mem_done = 1'b0;
        mem_instru = 32'd0;
    endtask

    task automatic do_branch(input logic [31:0] t);
        branch_or_not = 1'b1;
        branch_target = t;
        cyc();
        branch_or_not = 1'b0;
    endtask

    task automatic drain(input string name);
        logic [63:0] e, o;
        @(negedge clk_in);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL %s_missing: got nothing, expected pc=%h instr=%h", name, e[63:32], e[31:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL %s_issue: got pc=%h instr=%h, expected pc=%h instr=%h",
                             name, o[63:32], o[31:0], e[63:32], e[31:0]);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL %s_extra: got %0d unexpected issues (first pc=%h), expected 0",
                     name, obs_q.size(), obs_q[0][63:32]);
            obs_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; stall_in = 6'd0; branch_or_not = 1'b0;
        branch_target = 32'd0; mem_done = 1'b0; mem_instru = 32'd0;
        repeat (3) cyc();
        checks++; if (if_req !== 1'b0) begin failures++; $display("FAIL reset_if_req: got %b expected 0", if_req); end
        checks++; if (if_addr !== 32'd0) begin failures++; $display("FAIL reset_if_addr: got %h expected 0", if_addr); end
        checks++; if (output_pc !== 32'd0) begin failures++; $display("FAIL reset_pc: got %h expected 0", output_pc); end
        checks++; if (output_instru !== 32'd0) begin failures++; $display("FAIL reset_instru: got %h expected 0", output_instru); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall_req: got %b expected 0", stall_req); end
    endtask

    task automatic test_first_fetch();
        rst_in = 1'b0;
        cyc();
        checks++; if (if_req !== 1'b1 || if_addr !== 32'd0) begin failures++; $display("FAIL first_req: got %b/%h expected 1/0", if_req, if_addr); end
        checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL first_stall_req: got %b expected 1", stall_req); end
        serve(32'd0, 3);
        checks++; if (output_pc !== 32'd0 || output_instru !== 32'h13) begin failures++; $display("FAIL first_out: got %h/%h expected 0/13", output_pc, output_instru); end
        checks++; if (if_req !== 1'b0 || stall_req !== 1'b0) begin failures++; $display("FAIL first_release: got req=%b stall=%b expected 0/0", if_req, stall_req); end
        cyc();
        checks++; if (if_req !== 1'b1 || if_addr !== 32'd4) begin failures++; $display("FAIL first_next: got %b/%h expected 1/4", if_req, if_addr); end
        drain("first");
    endtask

    task automatic test_loop();
        serve(32'd4, 2);
        serve(32'd8, 2);
        serve(32'hC, 2);
        do_branch(32'd0);
        checks++; if (if_req !== 1'b0) begin failures++; $display("FAIL loop_branch_req: got %b expected 0", if_req); end
`ifdef IF_ICACHE_EN
        for (int i = 0; i < 4; i++) begin
            cyc();
            exp_q.push_back({32'(4 * i), word_of(32'(4 * i))});
            checks++;
            if (if_req !== 1'b0 || output_pc !== 32'(4 * i)) begin
                failures++;
                $display("FAIL loop_hit: got req=%b pc=%h expected 0/%h", if_req, output_pc, 32'(4 * i));
            end
        end
`else
        for (int i = 0; i < 4; i++) serve(32'(4 * i), 2);
`endif
        drain("loop");
    endtask

    task automatic test_branch_abort();
        rst_in = 1'b1;
        cyc();
        rst_in = 1'b0;
        serve(32'd0, 2);
        serve(32'd4, 2);
        wait_req(32'd8, "abort_wait");
        cyc();
        branch_or_not = 1'b1; branch_target = 32'h100;
        mem_done = 1'b1; mem_instru = word_of(32'd8);
        cyc();
        branch_or_not = 1'b0; mem_done = 1'b0; mem_instru = 32'd0;
        checks++; if (if_req !== 1'b0) begin failures++; $display("FAIL abort_req: got %b expected 0", if_req); end
        checks++; if (output_pc !== 32'd0 || output_instru !== 32'd0) begin failures++; $display("FAIL abort_out: got %h/%h expected 0/0", output_pc, output_instru); end
        serve(32'h100, 2);
        do_branch(32'd8);
`ifdef IF_ICACHE_EN
        cyc();
        exp_q.push_back({32'd8, word_of(32'd8)});
        checks++; if (if_req !== 1'b0) begin failures++; $display("FAIL abort_fill_hit: got req=%b expected 0", if_req); end
`else
        serve(32'd8, 2);
`endif
        drain("abort");
    endtask

    task automatic test_stall();
        do_branch(32'h20);
        wait_req(32'h20, "stall_wait");
        stall_in = 6'h3;
        cyc();
        mem_done = 1'b1; mem_instru = word_of(32'h20);
        cyc();
        mem_done = 1'b0; mem_instru = 32'd0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (if_req !== 1'b0 || stall_req !== 1'b1 || output_pc !== 32'd0 || output_instru !== 32'd0) begin
                failures++;
                $display("FAIL stall_hold: got req=%b stall=%b out=%h/%h expected 0/1/0/0", if_req, stall_req, output_pc, output_instru);
            end
            cyc();
        end
        stall_in = 6'd0;
        exp_q.push_back({32'h20, word_of(32'h20)});
        cyc();
        checks++; if (output_pc !== 32'h20 || output_instru !== word_of(32'h20)) begin failures++; $display("FAIL stall_release: got %h/%h expected 20/%h", output_pc, output_instru, word_of(32'h20)); end
        serve(32'h24, 2);
        drain("stall");
    endtask

    task automatic test_rdy();
        do_branch(32'h20);
`ifdef IF_ICACHE_EN
        cyc();
        exp_q.push_back({32'h20, word_of(32'h20)});
        rdy_in = 1'b0;
        repeat (5) begin
            cyc();
            checks++;
            if (output_pc !== 32'h20 || output_instru !== word_of(32'h20) || if_req !== 1'b0) begin
                failures++;
                $display("FAIL rdy_hold: got %h/%h req=%b expected 20/%h/0", output_pc, output_instru, if_req, word_of(32'h20));
            end
        end
        rdy_in = 1'b1;
        cyc();
        exp_q.push_back({32'h24, word_of(32'h24)});
        checks++; if (output_pc !== 32'h24) begin failures++; $display("FAIL rdy_resume: got %h expected 24", output_pc); end
`else
        wait_req(32'h20, "rdy_wait");
        rdy_in = 1'b0;
        repeat (5) begin
            cyc();
            checks++;
            if (if_req !== 1'b1 || if_addr !== 32'h20 || output_instru !== 32'd0) begin
                failures++;
                $display("FAIL rdy_hold: got req=%b addr=%h instr=%h expected 1/20/0", if_req, if_addr, output_instru);
            end
        end
        rdy_in = 1'b1;
        serve(32'h20, 2);
`endif
        drain("rdy");
    endtask

    task automatic test_reset_mid_miss();
        do_branch(32'h104);
        wait_req(32'h104, "rstmid_wait");
        rst_in = 1'b1;
        cyc();
        checks++; if (if_req !== 1'b0 || if_addr !== 32'd0 || stall_req !== 1'b0) begin failures++; $display("FAIL rstmid_req: got %b/%h/%b expected 0/0/0", if_req, if_addr, stall_req); end
        checks++; if (output_pc !== 32'd0 || output_instru !== 32'd0) begin failures++; $display("FAIL rstmid_out: got %h/%h expected 0/0", output_pc, output_instru); end
        rst_in = 1'b0;
        mem_done = 1'b1; mem_instru = 32'hDEADBEEF;
        cyc();
        mem_done = 1'b0; mem_instru = 32'd0;
        serve(32'd0, 2);
        drain("rstmid");
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_loop();
        test_branch_abort();
        test_stall();
        test_rdy();
        test_reset_mid_miss();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the RV32I pipeline. Holds the program counter, fetches one 32-bit instruction per request from the memory controller (optionally through a direct-mapped instruction cache), and presents `pc`/instruction pairs to the IF/ID pipeline register. Handles branch redirects from EX, and stalls from the stall controller. Raises its own stall request while a cache miss is outstanding.

## Interface
- `ICACHE_LINES`, 128: number of direct-mapped cache lines, one word each; power of two, ≥2.
- `clk_in` input 1: clock, all logic on rising edge.
- `rst_in` input 1: synchronous, active-high reset.
- `rdy_in` input 1: when 0, every register holds (clock-enable).
- `stall_in` input 6: stall vector from stall ctrl; bit 0 freezes this stage.
- `branch_or_not` input 1: EX redirect strobe, one cycle.
- `branch_target` input 32: redirect address, valid with `branch_or_not`.
- `mem_done` input 1: memory controller has completed the fetch; one-cycle pulse.
- `mem_instru` input 32: fetched word, valid with `mem_done`.
- `if_req` output 1: registered fetch request to memory controller, held high until `mem_done` or abort.
- `if_addr` output 32: registered fetch address, stable while `if_req`=1.
- `stall_req` output 1: combinational, 1 whenever state is WAIT_MEM.
- `output_pc` output 32: registered pc to IF/ID.
- `output_instru` output 32: registered instruction to IF/ID; 0 = bubble.

## Operation
- Registers: `pc`, `state` ∈ {IDLE, WAIT_MEM}, `if_req`, `if_addr`, outputs, cache arrays.
- Cache index = `pc[log2(ICACHE_LINES)+1:2]`, tag = `pc[31:log2(ICACHE_LINES)+2]`; one valid bit per line.
- Priority per enabled cycle (`rdy_in`=1): reset > branch > stall > normal.
- Branch (`branch_or_not`=1): `pc`<=`branch_target`; state<=IDLE; `if_req`<=0 (abort); outputs<=0. Any `mem_done` in the same cycle still fills the cache for `if_addr` but its word is not issued.
- Stall (`stall_in[0]`=1, no branch): `pc` and outputs hold; in WAIT_MEM, `if_req` and capture of `mem_done` still proceed, and the captured word is parked in a one-entry hold register and issued on the first unstalled cycle (no refetch).
- IDLE, not stalled:
  - Hit: `output_pc`<=`pc`, `output_instru`<=line data, `pc`<=`pc`+4.
  - Miss: `if_req`<=1, `if_addr`<=`pc`, state<=WAIT_MEM, outputs<=0.
- WAIT_MEM: `if_req` held. On `mem_done`: `if_req`<=0; line[index]<=`mem_instru`, tag written, valid<=1; if not stalled, output `if_addr`/`mem_instru`, `pc`<=`if_addr`+4, state<=IDLE; if stalled, park as above.
- `pc`+4 wraps modulo 2^32; no alignment check.
- Cache is never invalidated except by reset (no self-modifying code support).

## Timing
- Reset values: `pc`=0, state=IDLE, `if_req`=0, `if_addr`=0, `output_pc`=0, `output_instru`=0, all valid bits 0, hold register empty.
- Hit: instruction at `output_*` one cycle after `pc` is presented; sustained one instruction per cycle.
- Miss: `if_req` rises 1 cycle after miss detect; output appears the cycle after `mem_done`; total = memory latency + 2 cycles.
- Branch: first redirected instruction at output 1 cycle after the branch cycle on hit, 1 bubble minimum.
- Reset mid-miss: `if_req` drops next edge; a late `mem_done` while IDLE is ignored.
- `mem_done` while IDLE or `if_req`=0: ignored, no cache write.

## Configuration
- `IF_ICACHE_EN` defined: cache arrays built as above.
- Undefined: no arrays; every IDLE cycle is a miss, so each instruction costs a full memory access; all other behaviour identical.

## Test plan
- Reset, memory returns `0x00000013` for pc 0 after 3 cycles -> `if_req`=1 with `if_addr`=0, then `output_pc`=0, `output_instru`=0x13, `pc`=4.
- Loop of 4 instructions at 0x0–0xC run twice (`IF_ICACHE_EN`) -> second pass outputs one instruction per cycle, `if_req` stays 0.
- `branch_or_not`=1, `branch_target`=0x100 while WAIT_MEM for 0x8 -> `if_req` drops next cycle, outputs 0, next request `if_addr`=0x100; word for 0x8 never issued.
- `stall_in[0]`=1 across `mem_done` for 0x20 -> outputs hold, no second request; on release `output_pc`=0x20 issued once, `pc`=0x24.
- `rdy_in`=0 for 5 cycles mid-hit stream -> all outputs and `pc` unchanged, stream resumes without gap.
- `rst_in`=1 during WAIT_MEM, then spurious `mem_done` -> all outputs 0, no cache fill, fetch restarts at 0.
